window_3x3_extractor: RTL and testbench

//  Streaming 3x3 sliding-window generator. Sits between readOCM (raster pixel

---
 rtl/window_3x3_extractor_pkg.sv | 10 +
 rtl/window_3x3_extractor_line_buffer.sv | 26 ++
 rtl/window_3x3_extractor.sv | 133 +++++++++++++
 tb/tb_window_3x3_extractor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_extractor_pkg.sv
// Shared CNN image/pixel defaults used by the streaming blocks.
// The window extractor pulls its default sizes from here.
package window_3x3_extractor_pkg;

    localparam int CNN_DATA_W = 6;
    localparam int CNN_IMG_W  = 28;
    localparam int CNN_IMG_H  = 28;
    localparam int WIN_K      = 3;

endpackage

// File: rtl/window_3x3_extractor_line_buffer.sv
// One image line of pixels addressed by column: combinational read, write on accept.
// Contents are deliberately not reset; they are never exposed before being refilled.
module line_buffer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 28,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read returns the pre-write value, so lb1 -> lb2 cascade works in one cycle.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_3x3_extractor.sv
// Streaming 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers supply the upper rows; one window is flagged per in-image pixel.
module window_3x3_extractor
    import window_3x3_extractor_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = CNN_IMG_W,
    parameter int IMG_H  = CNN_IMG_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dv,
    output logic [DATA_W-1:0] x11,
    output logic [DATA_W-1:0] x12,
    output logic [DATA_W-1:0] x13,
    output logic [DATA_W-1:0] x21,
    output logic [DATA_W-1:0] x22,
    output logic [DATA_W-1:0] x23,
    output logic [DATA_W-1:0] x31,
    output logic [DATA_W-1:0] x32,
    output logic [DATA_W-1:0] x33,
    output logic              out_dv,
    output logic              frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic             out_dv_q;
    logic             frame_done_q;

    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;
    logic [DATA_W-1:0] new_col [WIN_K];

    assign accept   = enable & in_dv;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_dv_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_dv_q     <= accept && (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));
            frame_done_q <= accept && col_last && row_last;
        end
    end

    // lb1 holds row r-1, lb2 holds row r-2; lb2 is refilled from lb1's old value.
    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (in_data),
        .rdata_o (lb1_rd)
    );

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb2 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    assign new_col[0] = lb2_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = in_data;

    // Each window row is a 3-tap shift register fed by its element of the new column.
    for (genvar gi = 0; gi < WIN_K; gi++) begin : g_row
        logic [DATA_W-1:0] tap_q [WIN_K];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tap_q[0] <= '0;
                tap_q[1] <= '0;
                tap_q[2] <= '0;
            end else if (accept) begin
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
                tap_q[2] <= new_col[gi];
            end
        end
    end

    assign x11 = g_row[0].tap_q[0];
    assign x12 = g_row[0].tap_q[1];
    assign x13 = g_row[0].tap_q[2];
    assign x21 = g_row[1].tap_q[0];
    assign x22 = g_row[1].tap_q[1];
    assign x23 = g_row[1].tap_q[2];
    assign x31 = g_row[2].tap_q[0];
    assign x32 = g_row[2].tap_q[1];
    assign x33 = g_row[2].tap_q[2];

    assign out_dv     = out_dv_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_extractor.sv
// Bench for window_3x3_extractor on a 5x5 image: fixed vector table,
// directed corner sequences and random traffic against a frame-array model.
module tb_window_3x3_extractor;

    localparam int DW = 6;
    localparam int W  = 5;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          in_dv;
    logic [DW-1:0] in_data;
    logic [DW-1:0] x11, x12, x13, x21, x22, x23, x31, x32, x33;
    logic          out_dv;
    logic          frame_done;

    always #5 clk = ~clk;

    window_3x3_extractor #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_data    (in_data),
        .in_dv      (in_dv),
        .x11        (x11),
        .x12        (x12),
        .x13        (x13),
        .x21        (x21),
        .x22        (x22),
        .x23        (x23),
        .x31        (x31),
        .x32        (x32),
        .x33        (x33),
        .out_dv     (out_dv),
        .frame_done (frame_done)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int dv_cnt = 0;
    int fd_cnt = 0;

    // Frame-level reference: pixels stored by (row, col), windows cut from the array.
    int  m_r;
    int  m_c;
    int  img [H][W];
    int  last_win [9];
    bit  win_known;

    typedef struct {
        bit rstn;
        bit en;
        bit dv;
        int d;
        bit e_dv;
        bit e_fd;
        bit chk;
        int e_win [9];
    } vec_t;

    vec_t tbl [27];

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int act_win(input int k);
        case (k)
            0: return int'(x11);
            1: return int'(x12);
            2: return int'(x13);
            3: return int'(x21);
            4: return int'(x22);
            5: return int'(x23);
            6: return int'(x31);
            7: return int'(x32);
            default: return int'(x33);
        endcase
    endfunction

    task automatic step(input bit rstn, input bit en, input bit dv, input int d);
        bit e_dv;
        bit e_fd;
        rst_n   = rstn;
        enable  = en;
        in_dv   = dv;
        in_data = DW'(d % 64);
        e_dv    = 1'b0;
        e_fd    = 1'b0;
        if (!rstn) begin
            m_r = 0;
            m_c = 0;
            foreach (last_win[k]) last_win[k] = 0;
            win_known = 1'b1;
        end else if (en && dv) begin
            img[m_r][m_c] = d % 64;
            if (m_r >= 2 && m_c >= 2) begin
                e_dv = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        last_win[i*3+j] = img[m_r-2+i][m_c-2+j];
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            e_fd = (m_r == H-1) && (m_c == W-1);
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r = (m_r == H-1) ? 0 : m_r + 1;
            end
        end
        @(posedge clk);
        #1;
        $display("t=%0t rst_n=%0b en=%0b dv=%0b d=%0d -> out_dv=%0b fd=%0b win=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                 $time, rstn, en, dv, d % 64, out_dv, frame_done,
                 x11, x12, x13, x21, x22, x23, x31, x32, x33);
        check("out_dv", int'(out_dv), int'(e_dv));
        check("frame_done", int'(frame_done), int'(e_fd));
        if (out_dv) dv_cnt++;
        if (frame_done) fd_cnt++;
        if (win_known)
            for (int k = 0; k < 9; k++)
                check($sformatf("x%0d%0d", k/3 + 1, k%3 + 1), act_win(k), last_win[k]);
    endtask

    task automatic stream_frame(input int base);
        for (int p = 0; p < W*H; p++) step(1'b1, 1'b1, 1'b1, base + p);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        in_dv   = 1'b0;
        in_data = '0;

        // Table: reset, one back-to-back frame of raster indices, one idle cycle.
        tbl[0] = '{rstn: 1'b0, en: 1'b0, dv: 1'b0, d: 0, e_dv: 1'b0, e_fd: 1'b0,
                   chk: 1'b1, e_win: '{default: 0}};
        for (int p = 0; p < 25; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            tbl[p+1].rstn = 1'b1;
            tbl[p+1].en   = 1'b1;
            tbl[p+1].dv   = 1'b1;
            tbl[p+1].d    = p;
            tbl[p+1].e_dv = (r >= 2) && (c >= 2);
            tbl[p+1].e_fd = (p == 24);
            tbl[p+1].chk  = tbl[p+1].e_dv;
            for (int k = 0; k < 9; k++)
                tbl[p+1].e_win[k] = (r - 2 + k/3) * W + (c - 2 + k%3);
        end
        tbl[26] = '{rstn: 1'b1, en: 1'b1, dv: 1'b0, d: 0, e_dv: 1'b0, e_fd: 1'b0,
                    chk: 1'b0, e_win: '{default: 0}};

        @(negedge clk);
        dv_cnt = 0;
        fd_cnt = 0;
        for (int v = 0; v < 27; v++) begin
            rst_n   = tbl[v].rstn;
            enable  = tbl[v].en;
            in_dv   = tbl[v].dv;
            in_data = DW'(tbl[v].d);
            @(posedge clk);
            #1;
            $display("vec %0d d=%0d -> out_dv=%0b fd=%0b x33=%0d", v, tbl[v].d, out_dv, frame_done, x33);
            check($sformatf("tbl%0d out_dv", v), int'(out_dv), int'(tbl[v].e_dv));
            check($sformatf("tbl%0d frame_done", v), int'(frame_done), int'(tbl[v].e_fd));
            if (out_dv) dv_cnt++;
            if (frame_done) fd_cnt++;
            if (tbl[v].chk)
                for (int k = 0; k < 9; k++)
                    check($sformatf("tbl%0d x%0d%0d", v, k/3 + 1, k%3 + 1), act_win(k), tbl[v].e_win[k]);
        end
        check("tbl dv_count", dv_cnt, 9);
        check("tbl fd_count", fd_cnt, 1);

        // Random 1-3 cycle gaps in in_dv.
        step(1'b0, 1'b0, 1'b0, 0);
        dv_cnt = 0;
        for (int p = 0; p < W*H; p++) begin
            step(1'b1, 1'b1, 1'b1, p);
            repeat ($urandom_range(1, 3)) step(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 63)));
        end
        check("gap dv_count", dv_cnt, 9);

        // enable low with in_dv high for 4 cycles mid-row, after a valid window.
        dv_cnt = 0;
        for (int p = 0; p < 13; p++) step(1'b1, 1'b1, 1'b1, p);
        repeat (4) step(1'b1, 1'b0, 1'b1, int'($urandom_range(0, 63)));
        for (int p = 13; p < W*H; p++) step(1'b1, 1'b1, 1'b1, p);
        check("stall dv_count", dv_cnt, 9);

        // Reset mid-frame after pixel 17, then a fresh 100-based frame.
        for (int p = 0; p < 18; p++) step(1'b1, 1'b1, 1'b1, p);
        step(1'b0, 1'b1, 1'b1, 55);
        dv_cnt = 0;
        fd_cnt = 0;
        stream_frame(100);
        check("reset dv_count", dv_cnt, 9);
        check("reset fd_count", fd_cnt, 1);

        // Two frames back-to-back with distinct value ranges.
        dv_cnt = 0;
        fd_cnt = 0;
        stream_frame(0);
        stream_frame(32);
        check("2frame dv_count", dv_cnt, 18);
        check("2frame fd_count", fd_cnt, 2);

        // Random traffic with random enable/in_dv.
        for (int n = 0; n < 300; n++)
            step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 63)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
